// File: rtl/flash_block_reader.sv
// Reads a block of bytes from a byte-wide flash interface and repacks them
// little-endian into 32-bit words delivered through a small fall-through FIFO.
module flash_block_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [23:0]      base_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             mem_valid_o,
  output logic [23:0]      mem_addr_o,
  input  logic             mem_ready_i,
  input  logic [7:0]       mem_rdata_i,
  output logic             word_valid_o,
  output logic [31:0]      word_data_o,
  output logic             word_last_o,
  input  logic             word_ready_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                  state_q;
  logic [23:0]             addr_q;
  logic [LEN_W-1:0]        remain_q;
  logic [1:0]              bidx_q;
  logic [23:0]             acc_q;
  logic                    mem_valid_q;
  logic                    busy_q;
  logic                    done_q;

  logic [FIFO_DEPTH-1:0][31:0] fifo_data_q;
  logic [FIFO_DEPTH-1:0]       fifo_last_q;
  logic [AW-1:0]               wr_ptr_q;
  logic [AW-1:0]               rd_ptr_q;
  logic [AW:0]                 count_q;

  logic        hs;
  logic        last_byte;
  logic        push;
  logic        pop;
  logic        full;
  logic [31:0] push_word;

  assign hs        = mem_valid_q & mem_ready_i;
  assign last_byte = (remain_q == LEN_W'(1));
  assign push      = hs & ((bidx_q == 2'd3) | last_byte);
  assign pop       = (count_q != '0) & word_ready_i;
  assign full      = (count_q == (AW+1)'(FIFO_DEPTH));

  // Earlier bytes of the word come from the accumulator; bytes not yet received stay zero.
  always_comb begin
    push_word = '0;
    case (bidx_q)
      2'd0:    push_word = {24'h0, mem_rdata_i};
      2'd1:    push_word = {16'h0, mem_rdata_i, acc_q[7:0]};
      2'd2:    push_word = {8'h0, mem_rdata_i, acc_q[15:0]};
      default: push_word = {mem_rdata_i, acc_q};
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      bidx_q      <= '0;
      mem_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == DONE);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_q   <= base_addr_i;
            remain_q <= len_i;
            bidx_q   <= '0;
            if (len_i != '0) begin
              state_q <= FETCH;
              busy_q  <= 1'b1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        FETCH: begin
          if (hs) begin
            mem_valid_q <= 1'b0;
            addr_q      <= addr_q + 24'd1;
            remain_q    <= remain_q - LEN_W'(1);
            bidx_q      <= bidx_q + 2'd1;
            if (last_byte) state_q <= DRAIN;
          end else if (!mem_valid_q && !full) begin
            // No push can occur while a request is pending, so a slot stays free for its byte.
            mem_valid_q <= 1'b1;
          end
        end
        DRAIN: begin
          if (pop && word_last_o) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) acc_q <= push_word[23:0];
    if (push) begin
      fifo_data_q[wr_ptr_q] <= push_word;
      fifo_last_q[wr_ptr_q] <= last_byte;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = addr_q;
  assign word_valid_o = (count_q != '0);
  assign word_data_o  = word_valid_o ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign word_last_o  = word_valid_o ? fifo_last_q[rd_ptr_q] : 1'b0;

endmodule

// File: tb/tb_flash_block_reader.sv
// Directed bench for flash_block_reader: flash responder, word/done monitors and
// hand-computed expectations for each block scenario.
module tb_flash_block_reader;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic [23:0] base_addr_i;
  logic [15:0] len_i;
  logic        busy_o;
  logic        done_o;
  logic        mem_valid_o;
  logic [23:0] mem_addr_o;
  logic        mem_ready_i;
  logic [7:0]  mem_rdata_i;
  logic        word_valid_o;
  logic [31:0] word_data_o;
  logic        word_last_o;
  logic        word_ready_i;

  flash_block_reader #(.FIFO_DEPTH(4), .LEN_W(16)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o),
    .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
    .word_valid_o(word_valid_o), .word_data_o(word_data_o),
    .word_last_o(word_last_o), .word_ready_i(word_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flash responder: ready on the third sampled cycle of a request, data = byte index in block.
  int          nreq = 0;
  int          nvalid = 0;
  int          nb0 = 0;
  int          wcnt = 0;
  int          hold_err = 0;
  logic [23:0] hold_addr;
  logic [23:0] addr_log[$];

  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = 8'h0;
    hold_addr   = 24'h0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        mem_ready_i = 1'b0;
        wcnt = 0;
      end else if (mem_ready_i) begin
        mem_ready_i = 1'b0;
        nreq++;
        wcnt = 0;
      end else if (mem_valid_o) begin
        nvalid++;
        wcnt++;
        if (wcnt == 1) hold_addr = mem_addr_o;
        else if (mem_addr_o !== hold_addr) hold_err++;
        if (wcnt == 3) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = 8'(nreq - nb0);
          addr_log.push_back(mem_addr_o);
        end
      end
    end
  end

  logic [31:0] wd_q[$];
  logic        wl_q[$];
  int          done_cnt = 0;
  int          done_cyc = 0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (rstn_i && word_valid_o && word_ready_i) begin
        wd_q.push_back(word_data_o);
        wl_q.push_back(word_last_o);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  int w0, r0, d0, a0, v0, st_cyc;

  task automatic start_block(input logic [23:0] b, input logic [15:0] l);
    @(posedge clk_i); #1;
    w0 = wd_q.size(); r0 = nreq; d0 = done_cnt; a0 = addr_log.size(); v0 = nvalid;
    nb0 = nreq;
    base_addr_i = b;
    len_i = l;
    start_i = 1'b1;
    st_cyc = cyc;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (done_cnt == d0 && k < lim) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (done_cnt == d0) check("done_timeout", 0, 1);
    repeat (5) @(posedge clk_i);
    #1;
  endtask

  task automatic chk_word(input string tag, input int idx, input logic [31:0] d, input logic l);
    if (idx < wd_q.size()) begin
      check({tag, "_data"}, wd_q[idx], d);
      check({tag, "_last"}, wl_q[idx], l);
    end else begin
      check({tag, "_missing"}, 0, 1);
    end
  endtask

  task automatic chk_addr(input string tag, input int idx, input logic [23:0] a);
    if (idx < addr_log.size()) check(tag, addr_log[idx], a);
    else check({tag, "_missing"}, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic [31:0] exp_w;
    rstn_i = 1'b0; start_i = 1'b0; base_addr_i = 24'h0; len_i = 16'h0; word_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mem_valid", mem_valid_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_word_valid", word_valid_o, 0);
    check("rst_word_data", word_data_o, 0);
    check("rst_word_last", word_last_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    rstn_i = 1'b1;

    // len 8 at 0x100000
    start_block(24'h100000, 16'd8);
    check("t1_busy", busy_o, 1);
    wait_done(2000);
    check("t1_words", wd_q.size() - w0, 2);
    chk_word("t1_w0", w0, 32'h03020100, 1'b0);
    chk_word("t1_w1", w0 + 1, 32'h07060504, 1'b1);
    check("t1_reqs", nreq - r0, 8);
    check("t1_dones", done_cnt - d0, 1);
    chk_addr("t1_addr0", a0, 24'h100000);
    chk_addr("t1_addr7", a0 + 7, 24'h100007);
    check("t1_busy_end", busy_o, 0);

    // len 6: partial last word
    start_block(24'h000200, 16'd6);
    wait_done(2000);
    check("t2_words", wd_q.size() - w0, 2);
    check("t2_reqs", nreq - r0, 6);
    chk_word("t2_w0", w0, 32'h03020100, 1'b0);
    chk_word("t2_w1", w0 + 1, 32'h00000504, 1'b1);
    check("t2_dones", done_cnt - d0, 1);

    // len 0
    start_block(24'h000300, 16'd0);
    check("t3_busy", busy_o, 0);
    wait_done(100);
    check("t3_done_lat", done_cyc - st_cyc, 2);
    check("t3_valids", nvalid - v0, 0);
    check("t3_words", wd_q.size() - w0, 0);
    check("t3_dones", done_cnt - d0, 1);

    // address wrap
    start_block(24'hFFFFFE, 16'd4);
    wait_done(2000);
    chk_addr("t4_addr0", a0, 24'hFFFFFE);
    chk_addr("t4_addr1", a0 + 1, 24'hFFFFFF);
    chk_addr("t4_addr2", a0 + 2, 24'h000000);
    chk_addr("t4_addr3", a0 + 3, 24'h000001);
    check("t4_words", wd_q.size() - w0, 1);
    chk_word("t4_w0", w0, 32'h03020100, 1'b1);

    // back-pressure: FIFO fills after 16 bytes
    word_ready_i = 1'b0;
    start_block(24'h000400, 16'd32);
    repeat (300) @(posedge clk_i);
    #1;
    check("t5_stall_reqs", nreq - r0, 16);
    check("t5_stall_valid", mem_valid_o, 0);
    check("t5_head_valid", word_valid_o, 1);
    check("t5_head_data", word_data_o, 32'h03020100);
    check("t5_busy", busy_o, 1);
    check("t5_no_pops", wd_q.size() - w0, 0);
    word_ready_i = 1'b1;
    wait_done(3000);
    check("t5_words", wd_q.size() - w0, 8);
    check("t5_reqs", nreq - r0, 32);
    for (int i = 0; i < 8; i++) begin
      exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
      chk_word($sformatf("t5_w%0d", i), w0 + i, exp_w, (i == 7));
    end
    check("t5_dones", done_cnt - d0, 1);

    // reset during the third request
    start_block(24'h000800, 16'd8);
    k = 0;
    while (!((nreq - r0) == 2 && mem_valid_o) && k < 500) begin
      @(posedge clk_i); #1;
      k++;
    end
    check("t6_reached_req3", (nreq - r0 == 2) && mem_valid_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    check("t6_mem_valid", mem_valid_o, 0);
    check("t6_mem_addr", mem_addr_o, 0);
    check("t6_word_valid", word_valid_o, 0);
    check("t6_word_data", word_data_o, 0);
    check("t6_word_last", word_last_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_done", done_o, 0);
    w0 = wd_q.size(); d0 = done_cnt;
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    repeat (20) @(posedge clk_i);
    #1;
    check("t6_no_words", wd_q.size() - w0, 0);
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle_valid", mem_valid_o, 0);
    start_block(24'h000010, 16'd4);
    wait_done(2000);
    check("t6_words", wd_q.size() - w0, 1);
    chk_word("t6_w0", w0, 32'h03020100, 1'b1);
    check("t6_dones", done_cnt - d0, 1);
    check("t6_reqs", nreq - r0, 4);

    check("addr_hold_errs", hold_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flash_block_reader.md
FLASH_BLOCK_READER -- requirements
Module: flash_block_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning output word FIFO depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter LEN_W, default 16, meaning width of the byte-length input.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_i, input, 1 bit: single-cycle request to begin a block read.
REQ-006 SHALL have port base_addr_i, input, 24 bits: first flash byte address, sampled when start_i is accepted.
REQ-007 SHALL have port len_i, input, LEN_W bits: number of bytes to read, sampled when start_i is accepted.
REQ-008 SHALL have port busy_o, output, 1 bit: high from the accepted start until done_o.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port mem_valid_o, output, 1 bit: byte read request to the flash memory interface.
REQ-011 SHALL have port mem_addr_o, output, 24 bits: byte address of the current request.
REQ-012 SHALL have port mem_ready_i, input, 1 bit: request complete, with mem_rdata_i valid in the same cycle.
REQ-013 SHALL have port mem_rdata_i, input, 8 bits: returned flash byte.
REQ-014 SHALL have port word_valid_o, output, 1 bit: FIFO head valid.
REQ-015 SHALL have port word_data_o, output, 32 bits: FIFO head data.
REQ-016 SHALL have port word_last_o, output, 1 bit: FIFO head is the final word of the block.
REQ-017 SHALL have port word_ready_i, input, 1 bit: consumer accepts the head; a pop occurs when word_valid_o and word_ready_i are both high.

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, DRAIN and DONE.
REQ-019 IDLE + start_i: SHALL latch base_addr_i and len_i. If len_i≠0 it SHALL go to FETCH; if len_i=0 it SHALL go to DONE.
REQ-020 start_i outside IDLE SHALL be ignored, with no change to any state.
REQ-021 In FETCH, mem_valid_o SHALL rise no earlier than the cycle after entry, and only when the FIFO is not full.
REQ-022 Once raised, mem_valid_o and mem_addr_o SHALL hold stable until the cycle in which mem_ready_i is high.
REQ-023 On each mem_valid_o & mem_ready_i handshake, the block SHALL:
- capture mem_rdata_i;
- increment the address modulo 2^24 (0xFFFFFF wraps to 0x000000);
- decrement the remaining-byte count.
REQ-024 mem_valid_o SHALL be low in the cycle after each handshake; at most one request is outstanding at any time.
REQ-025 Bytes SHALL be packed little-endian: byte n of the block goes to word_data bits [8*(n mod 4)+7 : 8*(n mod 4)].
REQ-026 On the handshake of byte index 3 of a word, or of the final byte, the assembled word SHALL be written into the FIFO at the same clock edge.
REQ-027 Unfilled upper bytes of a partial final word SHALL be zero, and word_last SHALL be set only for the final word.
REQ-028 After the final byte's handshake, the FSM SHALL go to DRAIN. When the final word is popped it SHALL go to DONE.
REQ-029 DONE SHALL last one cycle: done_o=1, then the FSM returns to IDLE. busy_o SHALL be 1 in FETCH and DRAIN, and 0 in IDLE and DONE.
REQ-030 The FIFO SHALL support a simultaneous push and pop in the same cycle, including when full.
REQ-031 A full FIFO SHALL block only the issue of a new request. It SHALL never drop or overwrite data.
REQ-032 word_valid_o SHALL reflect FIFO non-empty, with zero-cycle fall-through from registered storage and no combinational path from mem_* inputs.
REQ-033 Number of words emitted SHALL equal ceil(len/4).

Reset
REQ-034 When rstn_i is low, the block SHALL immediately set the following:
- FSM=IDLE;
- FIFO empty;
- mem_valid_o=0;
- mem_addr_o=0;
- word_valid_o=0;
- word_data_o=0;
- word_last_o=0;
- busy_o=0;
- done_o=0.
REQ-035 Reset mid-block SHALL abandon the transfer, with no done_o pulse and no words emitted after reset deassertion.
REQ-036 After reset release, the first start_i SHALL be accepted normally.

Verification
REQ-037 The bench SHALL cover this scenario: base 0x100000, len 8, flash bytes 00..07, word_ready_i=1, mem_ready_i 3 cycles after valid.
- Required response: words 0x03020100 and 0x07060504 (last=1).
- Then exactly one done_o pulse.
REQ-038 The bench SHALL cover this scenario: len 6.
- Required response: second word 0x00000504 with last=1.
- Required response: exactly 6 requests and 2 words.
REQ-039 The bench SHALL cover this scenario: len 0.
- Required response: done_o pulse 2 cycles after start_i.
- Required response: no mem_valid_o and no words.
REQ-040 The bench SHALL cover this scenario: base 0xFFFFFE, len 4.
- Required response: addresses 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001.
REQ-041 The bench SHALL cover this scenario: word_ready_i=0, len 32.
- Required response: mem_valid_o stalls after 16 bytes, with 4 words held.
- Then word_ready_i=1: the remaining 4 words arrive, in order and intact.
REQ-042 The bench SHALL cover this scenario: rstn_i low during the 3rd request.
- Required response: all outputs return to reset values immediately.
- Then a new start with len 4 SHALL yield one correct word and one done_o pulse.
